// File: rtl/csla_ctrl_pkg.sv
// Shared control definitions for the nibble-serial add/subtract unit.
package csla_ctrl_pkg;

  // Width of the single time-shared adder slice.
  localparam int NIB_W = 4;

  // Sequencer states: waiting for operands, stepping nibbles, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } csla_state_t;

endpackage

// File: rtl/csla_4bit.sv
// 4-bit carry-select adder slice: the low pair ripples, and the high pair is
// precomputed for both incoming carries and selected by the low-pair carry.
module csla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  // Low pair ripple, both high-pair candidates, then the carry-select mux.
  always_comb begin
    lo   = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    hi0  = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    hi1  = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    sum  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
    cout = lo[2] ? hi1[2] : hi0[2];
  end

endmodule

// File: rtl/csla_nibble_serial_alu.sv
// Multi-cycle WIDTH-bit add/subtract unit. One csla_4bit slice is reused for
// every nibble, LSB first, with the inter-nibble carry held in a register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE, and out_valid is high only in DONE.
// The producer holds in_a/in_b/in_op stable until accepted. out_sum, out_cout
// and out_ovf are registered and stay unchanged until the next completion, so
// they are stable for as long as the consumer applies backpressure.
module csla_nibble_serial_alu
  import csla_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NNIB  = WIDTH / NIB_W;
  localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIB - 1);

  if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("csla_nibble_serial_alu: WIDTH must be a multiple of 4 and at least 8");
  end

  csla_state_t      state;
  logic [IDX_W-1:0] nib_idx;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;

  logic [IDX_W+1:0] bit_base;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_next;
  logic             ovf_next;

  // The one and only adder; subtraction arrives here as ~B with carry-in 1.
  csla_4bit u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Select the current nibble, merge its sum into the partial result and
  // form the signed overflow from the MSBs of the completed result.
  always_comb begin
    bit_base = {nib_idx, 2'b00};
    slice_a  = a_r[bit_base +: NIB_W];
    slice_b  = b_r[bit_base +: NIB_W];
    sum_next = sum_r;
    sum_next[bit_base +: NIB_W] = slice_sum;
    ovf_next = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_next[WIDTH-1] != a_r[WIDTH-1]);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Sequencer, operand/partial-result registers and the held result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      nib_idx  <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      sum_r    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (clear) begin
      // Abort wins over every transition; the last result stays on out_*.
      state   <= IDLE;
      nib_idx <= '0;
      carry   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r     <= in_a;
            b_r     <= in_op ? ~in_b : in_b;
            carry   <= in_op;
            nib_idx <= '0;
            sum_r   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_r <= sum_next;
          carry <= slice_cout;
          if (nib_idx == LAST_IDX) begin
            out_sum  <= sum_next;
            out_cout <= slice_cout;
            out_ovf  <= ovf_next;
            state    <= DONE;
          end else begin
            nib_idx <= nib_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csla_nibble_serial_alu.sv
// Directed bench for csla_nibble_serial_alu (WIDTH=16) with hand-computed
// expectations, followed by random operations against an arithmetic reference.
module tb_csla_nibble_serial_alu;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_op = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  csla_nibble_serial_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands in IDLE and let the next edge accept them.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  // Count edges from the accept edge until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 1;
    tick();
    while (out_valid !== 1'b1 && lat < 32) begin
      tick();
      lat++;
    end
  endtask

  // Full operation with out_ready high: latency, result, one-cycle out_valid.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic op, input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    start_op(a, b, op);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, {16'd0, out_sum}, {16'd0, es});
    check({tag, "_cout"}, {31'd0, out_cout}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    tick();
    check({tag, "_valid_one_cycle"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_sum_kept"}, {16'd0, out_sum}, {16'd0, es});
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb, rs;
    logic rop, rc, ro;
    int sr;

    // Reset state
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {16'd0, out_sum}, 32'd0);
    check("rst_out_cout", {31'd0, out_cout}, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic add/sub vectors
    do_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("sub_3_5",    16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_eq",     16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure: result held, new request ignored until DONE->IDLE
    out_ready = 1'b0;
    start_op(16'h1111, 16'h2222, 1'b0);
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'd4);
    check("bp_sum", {16'd0, out_sum}, 32'h3333);
    in_a     = 16'hA5A5;
    in_b     = 16'h5A5A;
    in_op    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid_held", {31'd0, out_valid}, 32'd1);
      check("bp_sum_held", {16'd0, out_sum}, 32'h3333);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_sum_kept", {16'd0, out_sum}, 32'h3333);
    tick();
    in_valid = 1'b0;
    check("bp_next_accepted", {31'd0, in_ready}, 32'd0);
    wait_done(lat);
    check("bp_next_latency", 32'(lat), 32'd4);
    check("bp_next_sum", {16'd0, out_sum}, 32'hFFFF);
    check("bp_next_cout", {31'd0, out_cout}, 32'd0);
    check("bp_next_ovf", {31'd0, out_ovf}, 32'd0);
    tick();

    // clear together with in_valid in IDLE: nothing accepted
    in_a     = 16'h0101;
    in_b     = 16'h0202;
    in_valid = 1'b1;
    clear    = 1'b1;
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
    check("clr_idle_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("clr_idle_no_valid", {31'd0, out_valid}, 32'd0);
    end

    // clear at the 2nd RUN cycle aborts the operation
    start_op(16'h4000, 16'h4000, 1'b0);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_run_idle", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("clr_run_no_valid", {31'd0, out_valid}, 32'd0);
      check("clr_run_sum_kept", {16'd0, out_sum}, 32'hFFFF);
      tick();
    end
    do_op("after_clear", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN
    start_op(16'h1234, 16'h1111, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_sum", {16'd0, out_sum}, 32'd0);
    check("arst_out_cout", {31'd0, out_cout}, 32'd0);
    check("arst_out_ovf", {31'd0, out_ovf}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("arst_no_partial_valid", {31'd0, out_valid}, 32'd0);
      check("arst_no_partial_sum", {16'd0, out_sum}, 32'd0);
    end

    // Random operations against an arithmetic reference
    for (int n = 0; n < 100; n++) begin
      ra  = W'($urandom_range(0, 65535));
      rb  = W'($urandom_range(0, 65535));
      rop = 1'($urandom_range(0, 1));
      if (rop) begin
        rs = ra - rb;
        rc = (ra >= rb);
        sr = int'($signed(ra)) - int'($signed(rb));
      end else begin
        rs = ra + rb;
        rc = ((32'(ra) + 32'(rb)) > 32'hFFFF);
        sr = int'($signed(ra)) + int'($signed(rb));
      end
      ro = (sr > 32767) || (sr < -32768);
      do_op("rand", ra, rb, rop, rs, rc, ro);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
